rst_seq_ctrl: RTL and testbench

Reset sequencer placed directly downstream of the system clock/reset generator. It consumes sys_clk and the raw sys_resetn, synchronizes reset de-assertion, and releases NUM_DOMAINS downstream reset domains in ascending order. Each domain must acknowledge initialization within a bounded time before the next domain is released. It reports overall readiness and any timeout fault, and supports a software-requested full re-sequence.

---
 rtl/rst_seq_pkg.sv | 21 ++
 rtl/rst_seq_ctrl_sync.sv | 28 ++
 rtl/rst_seq_ctrl.sv | 139 +++++++++++++
 tb/tb_rst_seq_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// rtl/rst_seq_pkg.sv - shared state encoding and width helper for the reset sequencer
//
// Contents:
//   seq_state_e : 3-bit sequencer state encoding (RESET..ERROR)
//   idx_w()     : width of a domain index, never less than 1 bit
package rst_seq_pkg;

    typedef enum logic [2:0] {
        S_RESET    = 3'd0,
        S_HOLD     = 3'd1,
        S_WAIT_ACK = 3'd2,
        S_GAP      = 3'd3,
        S_READY    = 3'd4,
        S_ERROR    = 3'd5
    } seq_state_e;

    function automatic int idx_w(input int num_domains);
        return (num_domains > 2) ? $clog2(num_domains) : 1;
    endfunction

endpackage

// File: rtl/rst_seq_ctrl_sync.sv
// rtl/rst_seq_ctrl_sync.sv - reset synchronizer with async assert and sync de-assert
//
// Ports:
//   clk      : clock the release is synchronized to
//   rst_n    : raw asynchronous active-low reset
//   rst_sync : synchronized reset-release level (1 = released)
module rst_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic rst_sync
);

    logic [SYNC_STAGES-1:0] sync_q;

    // A 1 is shifted in after release; assertion clears the whole chain at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_sync = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/rst_seq_ctrl.sv
// rtl/rst_seq_ctrl.sv - ordered reset release of NUM_DOMAINS domains with ack timeout
//
// Ports:
//   sys_clk     : single clock, rising edge
//   sys_resetn  : raw asynchronous active-low reset
//   sw_rst_req  : one-cycle request for a full re-sequence (ignored in RESET)
//   dom_ack     : per-domain init-done level
//   dom_resetn  : per-domain active-low reset, released in ascending order
//   sys_ready   : all domains released and acknowledged
//   timeout_err : sticky ack-timeout flag
//   err_domain  : index of the domain that timed out
//   seq_state   : current sequencer state
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_DOMAINS = 3,
    parameter int HOLD_CYCLES = 16,
    parameter int STEP_CYCLES = 8,
    parameter int ACK_TIMEOUT = 255,
    parameter int CNT_W       = 8,
    parameter int IDX_W       = idx_w(NUM_DOMAINS)
) (
    input  logic                   sys_clk,
    input  logic                   sys_resetn,
    input  logic                   sw_rst_req,
    input  logic [NUM_DOMAINS-1:0] dom_ack,
    output logic [NUM_DOMAINS-1:0] dom_resetn,
    output logic                   sys_ready,
    output logic                   timeout_err,
    output logic [IDX_W-1:0]       err_domain,
    output logic [2:0]             seq_state
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);

    logic             rst_sync_q;
    seq_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_next;

    assign idx_next  = idx + 1'b1;
    assign seq_state = state;

    rst_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rst_sync (
        .clk      (sys_clk),
        .rst_n    (sys_resetn),
        .rst_sync (rst_sync_q)
    );

    // One counter serves HOLD, GAP and WAIT_ACK; every state change clears it
    // so each phase counts from 0 on its entry edge.
    always_ff @(posedge sys_clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            state       <= S_RESET;
            cnt         <= '0;
            idx         <= '0;
            dom_resetn  <= '0;
            sys_ready   <= 1'b0;
            timeout_err <= 1'b0;
            err_domain  <= '0;
        end else if (sw_rst_req && state != S_RESET) begin
            state       <= S_HOLD;
            cnt         <= '0;
            idx         <= '0;
            dom_resetn  <= '0;
            sys_ready   <= 1'b0;
            timeout_err <= 1'b0;
            err_domain  <= '0;
        end else begin
            case (state)
                S_RESET: begin
                    if (rst_sync_q) begin
                        state <= S_HOLD;
                        cnt   <= '0;
                        idx   <= '0;
                    end
                end
                S_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state           <= S_WAIT_ACK;
                        cnt             <= '0;
                        dom_resetn[idx] <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT_ACK: begin
                    // Ack is checked first so it wins over a same-edge timeout.
                    if (dom_ack[idx]) begin
                        cnt <= '0;
                        if (idx == IDX_LAST) begin
                            state     <= S_READY;
                            sys_ready <= 1'b1;
                        end else begin
                            state <= S_GAP;
                        end
                    end else if (cnt == ACK_LAST) begin
                        state       <= S_ERROR;
                        cnt         <= '0;
                        dom_resetn  <= '0;
                        sys_ready   <= 1'b0;
                        timeout_err <= 1'b1;
                        err_domain  <= idx;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt == STEP_LAST) begin
                        state                <= S_WAIT_ACK;
                        cnt                  <= '0;
                        idx                  <= idx_next;
                        dom_resetn[idx_next] <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_READY: begin
                    // Terminal until sw_rst_req or async reset; acks are ignored.
                end
                S_ERROR: begin
                    // Terminal until sw_rst_req or async reset.
                end
                default: begin
                    state <= S_RESET;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb/tb_rst_seq_ctrl.sv - directed self-checking bench for rst_seq_ctrl
module tb_rst_seq_ctrl;

    logic       sys_clk;
    logic       sys_resetn;
    logic       sw_rst_req;
    logic [2:0] dom_ack;
    logic [2:0] dom_resetn;
    logic       sys_ready;
    logic       timeout_err;
    logic [1:0] err_domain;
    logic [2:0] seq_state;

    int edge_no;
    int tests;
    int fails;

    rst_seq_ctrl dut (
        .sys_clk     (sys_clk),
        .sys_resetn  (sys_resetn),
        .sw_rst_req  (sw_rst_req),
        .dom_ack     (dom_ack),
        .dom_resetn  (dom_resetn),
        .sys_ready   (sys_ready),
        .timeout_err (timeout_err),
        .err_domain  (err_domain),
        .seq_state   (seq_state)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // Edge 1 is the first rising edge with sys_resetn high.
    always @(posedge sys_clk) begin
        if (!sys_resetn) edge_no = 0;
        else             edge_no = edge_no + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the given edge, bounded.
    task automatic wait_edge(input int target);
        int guard;
        guard = 0;
        while (edge_no < target && guard < 2000) begin
            @(posedge sys_clk);
            #1;
            guard++;
        end
        if (edge_no != target) begin
            tests++;
            fails++;
            $error("FAIL wait_edge: observed edge %0d expected %0d", edge_no, target);
        end
    endtask

    // Assert reset now, hold across two clocks, release mid-period.
    task automatic apply_reset();
        sys_resetn = 1'b0;
        #1;
        repeat (2) @(posedge sys_clk);
        #3;
        sys_resetn = 1'b1;
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        edge_no    = 0;
        sys_resetn = 1'b0;
        sw_rst_req = 1'b0;
        dom_ack    = 3'b111;

        // Scenario 1: power-up, all acks high
        #2;
        chk("rst_dom_resetn", dom_resetn, 3'b000);
        chk("rst_sys_ready", sys_ready, 1'b0);
        chk("rst_timeout", timeout_err, 1'b0);
        chk("rst_err_domain", err_domain, 2'd0);
        chk("rst_state", seq_state, 3'd0);
        apply_reset();
        wait_edge(2);  chk("s1_e2_state", seq_state, 3'd0);
        wait_edge(3);  chk("s1_e3_state", seq_state, 3'd1);
        wait_edge(18); chk("s1_e18_dom", dom_resetn, 3'b000);
        wait_edge(19); chk("s1_e19_dom", dom_resetn, 3'b001);
                       chk("s1_e19_state", seq_state, 3'd2);
        wait_edge(20); chk("s1_e20_state", seq_state, 3'd3);
        wait_edge(27); chk("s1_e27_dom", dom_resetn, 3'b001);
        wait_edge(28); chk("s1_e28_dom", dom_resetn, 3'b011);
        wait_edge(36); chk("s1_e36_dom", dom_resetn, 3'b011);
        wait_edge(37); chk("s1_e37_dom", dom_resetn, 3'b111);
                       chk("s1_e37_ready", sys_ready, 1'b0);
        wait_edge(38); chk("s1_e38_ready", sys_ready, 1'b1);
                       chk("s1_e38_state", seq_state, 3'd4);
        dom_ack = 3'b000;
        wait_edge(42); chk("s1_ack_ignored", sys_ready, 1'b1);
        dom_ack = 3'b111;

        // sw_rst_req in READY sampled at edge 45
        wait_edge(44);
        sw_rst_req = 1'b1;
        wait_edge(45);
        sw_rst_req = 1'b0;
        chk("sw_ready_dom", dom_resetn, 3'b000);
        chk("sw_ready_rdy", sys_ready, 1'b0);
        chk("sw_ready_state", seq_state, 3'd1);
        wait_edge(60); chk("sw_e60_dom", dom_resetn, 3'b000);
        wait_edge(61); chk("sw_e61_dom", dom_resetn, 3'b001);
        wait_edge(80); chk("sw_e80_ready", sys_ready, 1'b1);

        // Scenario 2: domain 1 never acks -> ERROR at 283
        @(negedge sys_clk);
        dom_ack = 3'b101;
        sys_resetn = 1'b0;
        #1;
        chk("s2_async_dom", dom_resetn, 3'b000);
        chk("s2_async_rdy", sys_ready, 1'b0);
        chk("s2_async_state", seq_state, 3'd0);
        repeat (2) @(posedge sys_clk);
        #3;
        sys_resetn = 1'b1;
        wait_edge(28);  chk("s2_e28_dom", dom_resetn, 3'b011);
        wait_edge(282); chk("s2_e282_state", seq_state, 3'd2);
                        chk("s2_e282_to", timeout_err, 1'b0);
        wait_edge(283); chk("s2_e283_state", seq_state, 3'd5);
                        chk("s2_e283_to", timeout_err, 1'b1);
                        chk("s2_e283_errdom", err_domain, 2'd1);
                        chk("s2_e283_dom", dom_resetn, 3'b000);
                        chk("s2_e283_rdy", sys_ready, 1'b0);
        wait_edge(289);
        sw_rst_req = 1'b1;
        wait_edge(290);
        sw_rst_req = 1'b0;
        chk("s2_sw_to", timeout_err, 1'b0);
        chk("s2_sw_errdom", err_domain, 2'd0);
        chk("s2_sw_state", seq_state, 3'd1);
        wait_edge(306); chk("s2_e306_dom", dom_resetn, 3'b001);

        // Scenario 3: ack on the timeout edge wins
        dom_ack = 3'b000;
        apply_reset();
        wait_edge(273);
        chk("s3_e273_state", seq_state, 3'd2);
        dom_ack = 3'b001;
        wait_edge(274);
        dom_ack = 3'b000;
        chk("s3_e274_state", seq_state, 3'd3);
        chk("s3_e274_to", timeout_err, 1'b0);
        wait_edge(282); chk("s3_e282_dom", dom_resetn, 3'b011);
        wait_edge(283); chk("s3_e283_to", timeout_err, 1'b0);

        // Scenario 4: other acks ignored, domain 0 times out at 274
        dom_ack = 3'b100;
        apply_reset();
        wait_edge(273); chk("s4_e273_dom", dom_resetn, 3'b001);
                        chk("s4_e273_state", seq_state, 3'd2);
        wait_edge(274); chk("s4_e274_state", seq_state, 3'd5);
                        chk("s4_e274_errdom", err_domain, 2'd0);
                        chk("s4_e274_to", timeout_err, 1'b1);
                        chk("s4_e274_dom", dom_resetn, 3'b000);

        // Scenario 5: async reset mid-GAP, restart matches scenario 1
        dom_ack = 3'b111;
        apply_reset();
        wait_edge(24);
        chk("s5_gap_state", seq_state, 3'd3);
        #3;
        sys_resetn = 1'b0;
        #1;
        chk("s5_async_dom", dom_resetn, 3'b000);
        chk("s5_async_state", seq_state, 3'd0);
        chk("s5_async_rdy", sys_ready, 1'b0);
        repeat (2) @(posedge sys_clk);
        #3;
        sys_resetn = 1'b1;
        sw_rst_req = 1'b1;           // sampled at edge 1 while in RESET: ignored
        wait_edge(1);
        sw_rst_req = 1'b0;
        wait_edge(2);  chk("s5_e2_state", seq_state, 3'd0);
        wait_edge(3);  chk("s5_e3_state", seq_state, 3'd1);
        wait_edge(18); chk("s5_e18_dom", dom_resetn, 3'b000);
        wait_edge(19); chk("s5_e19_dom", dom_resetn, 3'b001);
        wait_edge(28); chk("s5_e28_dom", dom_resetn, 3'b011);
        wait_edge(37); chk("s5_e37_dom", dom_resetn, 3'b111);
        wait_edge(38); chk("s5_e38_ready", sys_ready, 1'b1);
                       chk("s5_e38_state", seq_state, 3'd4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
